// File: rtl/restoring_divider_pkg.sv
// Shared definitions for the restoring divider: FSM state encoding and
// iteration-counter sizing.
package restoring_divider_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Counter must hold the value WIDTH itself, not just WIDTH-1.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/restoring_divider_cla_sub.sv
// Carry-lookahead subtractor: Diff = A + ~B + 1. c_o=1 means no borrow.
module cla_sub #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Diff,
  output logic             c_o
);

  logic [WIDTH-1:0] w_b_n;
  logic [WIDTH-1:0] w_g;
  logic [WIDTH-1:0] w_p;
  logic [WIDTH:0]   w_c;
  logic             w_pchain;

  assign w_b_n = ~B;
  assign w_g   = A & w_b_n;
  assign w_p   = A ^ w_b_n;

  // Each carry is the flattened sum of generate terms, with c_in tied to 1.
  always_comb begin
    w_c      = '0;
    w_c[0]   = 1'b1;
    w_pchain = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      w_pchain = w_p[i];
      w_c[i+1] = w_g[i];
      for (int j = i - 1; j >= 0; j--) begin
        w_c[i+1] = w_c[i+1] | (w_pchain & w_g[j]);
        w_pchain = w_pchain & w_p[j];
      end
      w_c[i+1] = w_c[i+1] | w_pchain;
    end
  end

  assign Diff = w_p ^ w_c[WIDTH-1:0];
  assign c_o  = w_c[WIDTH];

endmodule

// File: rtl/restoring_divider.sv
// Multi-cycle unsigned restoring divider with start/done handshake.
// One quotient bit per clock through a CLA trial subtractor.
module restoring_divider
  import restoring_divider_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);

  state_t           r_state;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH:0]   w_r_sh;
  logic [WIDTH:0]   w_diff;
  logic             w_c_o;
  logic [WIDTH:0]   w_r_next;
  logic [WIDTH-1:0] w_q_next;

  // Shift {R,Q} left by one: Q's MSB moves into R's LSB.
  assign w_r_sh = (r_rem << 1) | (WIDTH + 1)'(r_q[WIDTH-1]);

  cla_sub #(
    .WIDTH(WIDTH + 1)
  ) u_sub (
    .A   (w_r_sh),
    .B   ({1'b0, r_d}),
    .Diff(w_diff),
    .c_o (w_c_o)
  );

  assign w_r_next = w_c_o ? w_diff : w_r_sh;
  assign w_q_next = {r_q[WIDTH-2:0], w_c_o};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_rem       <= '0;
      r_q         <= '0;
      r_d         <= '0;
      r_cnt       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy <= 1'b1;
            if (divisor != '0) begin
              r_rem       <= '0;
              r_q         <= dividend;
              r_d         <= divisor;
              r_cnt       <= CW'(WIDTH);
              div_by_zero <= 1'b0;
              r_state     <= ST_CALC;
            end else begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              r_state     <= ST_DONE;
            end
          end
        end
        ST_CALC: begin
          r_rem <= w_r_next;
          r_q   <= w_q_next;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            quotient  <= w_q_next;
            remainder <= w_r_next[WIDTH-1:0];
            done      <= 1'b1;
            r_state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_restoring_divider.sv
// Scoreboard bench for restoring_divider: directed corner cases, random ops,
// and an exhaustive back-to-back sweep against a / and % reference.
module tb_restoring_divider;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  restoring_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    int q;
    int r;
    int dbz;
    int gap;
    string tag;
  } exp_t;

  exp_t sb[$];
  int   errors    = 0;
  int   checks    = 0;
  int   cyc       = 0;
  int   last_done = -1;
  int   n_done    = 0;
  int   n_push    = 0;
  int   n_flushed = 0;

  always @(posedge clk) cyc++;

  function automatic void check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic exp_t model(input int a, input int b, input int gap, input string tag);
    exp_t e;
    e.gap = gap;
    e.tag = tag;
    if (b == 0) begin
      e.q   = (1 << W) - 1;
      e.r   = a;
      e.dbz = 1;
    end else begin
      e.q   = a / b;
      e.r   = a % b;
      e.dbz = 0;
    end
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (done) begin
      exp_t e;
      n_done++;
      if (sb.size() == 0) begin
        check("spurious_done", 1, 0);
      end else begin
        e = sb.pop_front();
        check({e.tag, "_quotient"}, int'(quotient), e.q);
        check({e.tag, "_remainder"}, int'(remainder), e.r);
        check({e.tag, "_div_by_zero"}, int'(div_by_zero), e.dbz);
        check({e.tag, "_busy_with_done"}, int'(busy), 1);
        if (e.gap != 0 && last_done >= 0)
          check({e.tag, "_b2b_interval"}, cyc - last_done, e.gap);
      end
      last_done = cyc;
    end
  end

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while (busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      $display("FAIL idle_timeout: busy still %0d after %0d cycles", busy, t);
      errors++;
      checks++;
    end
  endtask

  // Returns just after the accepting edge k.
  task automatic issue(input int a, input int b, input string tag);
    wait_idle();
    dividend = W'(a);
    divisor  = W'(b);
    start    = 1'b1;
    sb.push_back(model(a, b, 0, tag));
    n_push++;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Index m = negedge following edge k+m.
  task automatic measure(input int a, input int b, input int exp_done_at,
                         input int exp_busy, input string tag);
    int busy_cnt;
    int done_at;
    busy_cnt = 0;
    done_at  = -1;
    issue(a, b, tag);
    for (int m = 0; m < 16; m++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done && done_at < 0) done_at = m;
    end
    check({tag, "_done_latency"}, done_at, exp_done_at);
    check({tag, "_busy_cycles"}, busy_cnt, exp_busy);
  endtask

  initial begin
    int t;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_quotient", int'(quotient), 0);
    check("reset_remainder", int'(remainder), 0);
    check("reset_div_by_zero", int'(div_by_zero), 0);
    rst = 1'b0;

    measure(14, 3, W, W + 1, "d14_3");
    issue(15, 15, "d15_15");
    issue(9, 1, "d9_1");
    issue(0, 7, "d0_7");
    issue(5, 9, "d5_9");
    measure(11, 0, 0, 1, "d11_0");
    issue(6, 4, "d6_4_after_dbz");

    // Start pulsed mid-calculation with other operands must be ignored.
    issue(14, 3, "ignore_14_3");
    @(negedge clk);
    dividend = 4'd5;
    divisor  = 4'd1;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    @(negedge clk);
    dividend = 4'd7;
    divisor  = 4'd0;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;

    // Reset during iteration 2 discards the operation.
    issue(13, 2, "aborted");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    n_flushed += sb.size();
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_quotient", int'(quotient), 0);
    check("midrst_remainder", int'(remainder), 0);
    check("midrst_div_by_zero", int'(div_by_zero), 0);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    issue(13, 2, "restart_13_2");

    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      issue(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), "rand");
    end

    // Exhaustive sweep with start held high.
    wait_idle();
    start = 1'b1;
    for (int i = 0; i < 256; i++) begin
      int a;
      int b;
      a = i >> 4;
      b = i & 15;
      t = 0;
      while (busy && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (t >= 100) check("b2b_timeout", t, 0);
      dividend = W'(a);
      divisor  = W'(b);
      sb.push_back(model(a, b, (i == 0) ? 0 : ((b == 0) ? 2 : W + 2), "sweep"));
      n_push++;
      @(posedge clk);
      #1;
      if (i == 255) start = 1'b0;
      @(negedge clk);
    end

    t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("drain_pending", sb.size(), 0);
    repeat (4) @(negedge clk);
    check("done_count", n_done, n_push - n_flushed);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
